event_polarity_persistence_filter: RTL

//  Parametrised polarity-persistence filter for the event-camera input path; sits between sensor event decode and downstream processing.

---
 rtl/event_polarity_persistence_filter_pkg.sv | 30 +++
 rtl/event_polarity_persistence_filter_if.sv | 38 +++
 rtl/event_polarity_persistence_filter_fifo.sv | 73 +++++++
 rtl/event_polarity_persistence_filter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/event_polarity_persistence_filter_pkg.sv
// Shared types for the event polarity-persistence filter: FSM state enum,
// reference event layout and a saturating counter helper.
// Ports: none (package).
package evf_pkg;

   // Reference widths for the packed event layout (x, y, t, p; MSB first).
   localparam int EVF_X_W = 8;
   localparam int EVF_Y_W = 8;
   localparam int EVF_T_W = 16;
   localparam int EVF_P_W = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      EMIT = 2'd2
   } evf_state_t;

   typedef struct packed {
      logic [EVF_X_W-1:0] x;
      logic [EVF_Y_W-1:0] y;
      logic [EVF_T_W-1:0] t;
      logic [EVF_P_W-1:0] p;
   } evf_event_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/event_polarity_persistence_filter_if.sv
// Event-stream bundle: input valid/ready + event fields, output valid/ready +
// FIFO head fields, and FIFO occupancy.
// Modports: master = event source / sink side, slave = filter side.
interface event_polarity_persistence_filter_if #(
   parameter int X_W        = 8,
   parameter int Y_W        = 8,
   parameter int T_W        = 16,
   parameter int P_W        = 1,
   parameter int FIFO_DEPTH = 8
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [X_W-1:0]   in_x;
   logic [Y_W-1:0]   in_y;
   logic [T_W-1:0]   in_t;
   logic [P_W-1:0]   in_p;

   logic             out_valid;
   logic             out_ready;
   logic [X_W-1:0]   out_x;
   logic [Y_W-1:0]   out_y;
   logic [T_W-1:0]   out_t;
   logic [P_W-1:0]   out_p;
   logic [LVL_W-1:0] fifo_level;

   modport master (
      output in_valid, in_x, in_y, in_t, in_p, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_t, out_p, fifo_level
   );

   modport slave (
      input  in_valid, in_x, in_y, in_t, in_p, out_ready,
      output in_ready, out_valid, out_x, out_y, out_t, out_p, fifo_level
   );

endinterface

// File: rtl/event_polarity_persistence_filter_fifo.sv
// evf_fifo: generic first-word-fall-through FIFO with registered level.
// Latency: a push is visible at rd_dat_o on the next clock; push+pop when full is legal.
// Backpressure: full_o is exported; push while full without a pop is ignored, pop while empty is ignored.
// Ports: clk, rst_n, push_i/push_dat_i, pop_i, rd_dat_o, full_o, empty_o, level_o.
module evf_fifo #(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] last_q;
   logic             push_ok, pop_ok;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign level_o = level_q;

   assign pop_ok  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_ok = push_i & (~full_o | pop_ok);

   always_comb begin
      level_d = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LVL_W'(1);
      end else if (!push_ok && pop_ok) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         last_q   <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
         level_q <= level_d;
      end
   end

   // Storage needs no reset: it is only observed through level_q.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // When empty, present the last popped word instead of stale storage.
   assign rd_dat_o = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/event_polarity_persistence_filter.sv
// Polarity-persistence filter: holds each event HOLD_CYCLES clocks, drops it if an opposite-polarity event arrives.
// Latency: surviving event pushed HOLD_CYCLES+1 clocks after capture, visible at out_* one clock later.
// Backpressure: in_ready low while a survivor waits for FIFO space; output FIFO absorbs downstream stalls.
// Ports: clk, rst_n (async active-low), bus (slave modport: in_*/out_*/fifo_level).
// Optional EVF_STATS_EN adds 16-bit saturating stat_pass / stat_drop / stat_merge outputs.
module event_polarity_persistence_filter
   import evf_pkg::*;
#(
   parameter int X_W         = 8,
   parameter int Y_W         = 8,
   parameter int T_W         = 16,
   parameter int P_W         = 1,
   parameter int HOLD_CYCLES = 4,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic clk,
   input  logic rst_n,
   event_polarity_persistence_filter_if.slave bus
`ifdef EVF_STATS_EN
   ,
   output logic [15:0] stat_pass,
   output logic [15:0] stat_drop,
   output logic [15:0] stat_merge
`endif
);

   localparam int         EV_W     = X_W + Y_W + T_W + P_W;
   localparam logic [7:0] HOLD_CNT = 8'(HOLD_CYCLES);

   evf_state_t      state_q, state_d;
   logic [EV_W-1:0] cand_q, cand_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [EV_W-1:0] in_ev, head_ev;
   logic            in_xfer, out_pop, p_diff, push, fifo_full, fifo_empty;

   assign in_ev = {bus.in_x, bus.in_y, bus.in_t, bus.in_p};

   // rst_n gates in_ready so nothing is accepted while reset is asserted.
   assign bus.in_ready = rst_n & (state_q != EMIT);
   assign in_xfer      = bus.in_valid & bus.in_ready;
   assign out_pop      = bus.out_valid & bus.out_ready;
   assign p_diff       = (bus.in_p != cand_q[P_W-1:0]);

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               cand_d  = in_ev;
               cnt_d   = 8'd1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Contradiction beats window expiry; same polarity is simply absorbed.
            if (in_xfer && p_diff) begin
               cand_d = in_ev;
               cnt_d  = 8'd1;
            end else if (cnt_q == HOLD_CNT) begin
               state_d = EMIT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         EMIT: begin
            if (!fifo_full || out_pop) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   evf_fifo #(
      .WIDTH (EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_dat_i (cand_q),
      .pop_i      (out_pop),
      .rd_dat_o   (head_ev),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (bus.fifo_level)
   );

   assign bus.out_valid = ~fifo_empty;
   assign {bus.out_x, bus.out_y, bus.out_t, bus.out_p} = head_ev;

`ifdef EVF_STATS_EN
   logic [15:0] pass_q, drop_q, merge_q;
   logic        hold_xfer;

   assign hold_xfer = (state_q == HOLD) & in_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_q  <= '0;
         drop_q  <= '0;
         merge_q <= '0;
      end else begin
         pass_q  <= sat_inc(pass_q, push);
         drop_q  <= sat_inc(drop_q, hold_xfer & p_diff);
         merge_q <= sat_inc(merge_q, hold_xfer & ~p_diff);
      end
   end

   assign stat_pass  = pass_q;
   assign stat_drop  = drop_q;
   assign stat_merge = merge_q;
`endif

endmodule
